// File: rtl/mont_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mont_arbiter
//  Purpose  : Round-robin sharing of one montgomery multiplier core between
//             NUM_REQ requesters; sequences core reset/start/done and returns
//             a one-cycle response to the owning requester.
//             Optional watchdog: define MONT_ARB_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mont_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int WIDTH          = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*WIDTH-1:0]   req_m,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_error,
    output logic                       busy,
    output logic                       core_resetn,
    output logic                       core_start,
    output logic [WIDTH-1:0]           core_a,
    output logic [WIDTH-1:0]           core_b,
    output logic [WIDTH-1:0]           core_m,
    input  logic [WIDTH-1:0]           core_result,
    input  logic                       core_done
);

    localparam int              c_IW   = $clog2(NUM_REQ);
    localparam logic [c_IW:0]   c_NUM  = (c_IW + 1)'(NUM_REQ);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mont_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_IW-1:0]     r_ptr;
    logic [c_IW-1:0]     r_owner;
    logic [WIDTH-1:0]    r_core_a;
    logic [WIDTH-1:0]    r_core_b;
    logic [WIDTH-1:0]    r_core_m;
    logic [WIDTH-1:0]    r_rsp_result;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic                r_rsp_error;
    logic                r_busy;
    logic                r_core_resetn;
    logic                r_core_start;

    logic                w_grant_any;
    logic [c_IW-1:0]     w_grant_idx;
    logic [c_IW:0]       w_rr_idx;
    logic [NUM_REQ-1:0]  w_grant_oh;
    logic [NUM_REQ-1:0]  w_owner_oh;
    logic [WIDTH-1:0]    w_sel_a;
    logic [WIDTH-1:0]    w_sel_b;
    logic [WIDTH-1:0]    w_sel_m;
    logic                w_timeout;

    // Search starts at the pointer and wraps; the first valid requester wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_rr_idx    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_rr_idx = {1'b0, r_ptr} + (c_IW + 1)'(off);
            if (w_rr_idx >= c_NUM) begin
                w_rr_idx = w_rr_idx - c_NUM;
            end
            if (!w_grant_any && req_valid[w_rr_idx[c_IW-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_rr_idx[c_IW-1:0];
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        w_owner_oh = '0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_m    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_owner_oh[i] = (c_IW'(i) == r_owner);
            if (c_IW'(i) == w_grant_idx) begin
                w_grant_oh[i] = w_grant_any;
                w_sel_a       = req_a[i*WIDTH +: WIDTH];
                w_sel_b       = req_b[i*WIDTH +: WIDTH];
                w_sel_m       = req_m[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MONT_ARB_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TW-1:0] r_wait_cnt;

    // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + c_TW'(1);
        end
    end

    assign w_timeout = (r_wait_cnt == c_TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_core_a      <= '0;
            r_core_b      <= '0;
            r_core_m      <= '0;
            r_rsp_result  <= '0;
            r_rsp_valid   <= '0;
            r_rsp_error   <= 1'b0;
            r_busy        <= 1'b0;
            r_core_resetn <= 1'b0;
            r_core_start  <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_error  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_owner  <= w_grant_idx;
                        r_core_a <= w_sel_a;
                        r_core_b <= w_sel_b;
                        r_core_m <= w_sel_m;
                        r_busy   <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_core_resetn <= 1'b1;
                    r_core_start  <= 1'b1;
                    r_state       <= ST_START;
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        r_rsp_result <= core_result;
                        r_rsp_valid  <= w_owner_oh;
                        r_state      <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_result <= '0;
                        r_rsp_valid  <= w_owner_oh;
                        r_rsp_error  <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ptr         <= (r_owner == c_LAST) ? '0 : r_owner + c_IW'(1);
                    r_busy        <= 1'b0;
                    r_core_resetn <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_busy        <= 1'b0;
                    r_core_resetn <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE) ? w_grant_oh : '0;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_error   = r_rsp_error;
    assign busy        = r_busy;
    assign core_resetn = r_core_resetn;
    assign core_start  = r_core_start;
    assign core_a      = r_core_a;
    assign core_b      = r_core_b;
    assign core_m      = r_core_m;

endmodule
`default_nettype wire

// File: tb/tb_mont_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mont_arbiter
//  Purpose  : Self-checking bench for mont_arbiter with a cycle-offset
//             transaction model and a simple multiplier core stand-in.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mont_arbiter;

    localparam int N   = 2;
    localparam int W   = 16;
    localparam int LAT = 10;
`ifdef MONT_ARB_TIMEOUT_EN
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 4096;
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b, req_m;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [W-1:0]   rsp_result;
    logic           rsp_error, busy, core_resetn, core_start;
    logic [W-1:0]   core_a, core_b, core_m, core_result;
    logic           core_done;

    mont_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_a(req_a), .req_b(req_b), .req_m(req_m),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .busy(busy), .core_resetn(core_resetn),
        .core_start(core_start), .core_a(core_a), .core_b(core_b), .core_m(core_m),
        .core_result(core_result), .core_done(core_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Core stand-in: result = a*b mod m, done pulse LAT cycles after start.
    bit inject_done = 1'b0;
    bit never_done  = 1'b0;
    int done_cyc    = -1;
    logic [W-1:0] core_res_q = '0;
    initial begin
        int pa, pb, pm;
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!core_resetn) begin
                done_cyc = -1;
            end else if (core_start && !never_done) begin
                pa = int'(core_a);
                pb = int'(core_b);
                pm = (core_m == '0) ? 1 : int'(core_m);
                core_res_q = W'((pa * pb) % pm);
                done_cyc   = cyc + LAT;
            end
            core_done   = inject_done || (cyc == done_cyc);
            core_result = (cyc == done_cyc) ? core_res_q : W'($urandom);
        end
    end

    function automatic int pick(input logic [N-1:0] rv, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (rv[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    // Transaction model: all timing derived from the accept cycle and the
    // cycle in which the core reported done.
    initial begin
        int m_busy = 0, m_acc = 0, m_resp = -1, m_owner = 0, m_ptr = 0;
        int d, g;
        bit m_perr = 1'b0;
        logic [W-1:0] m_a = '0, m_b = '0, m_m = '0, m_last = '0, m_pend = '0;
        logic [N-1:0] e_ready, e_rv;
        logic e_busy, e_rn, e_start, e_err;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_busy = 0; m_ptr = 0; m_resp = -1;
                m_a = '0; m_b = '0; m_m = '0; m_last = '0;
            end
            d = cyc - m_acc;
            e_rv = '0; e_err = 1'b0; e_start = 1'b0;
            if (m_busy == 0) begin
                g = pick(req_valid, m_ptr);
                e_ready = (g >= 0) ? N'(1 << g) : '0;
                e_busy = 1'b0; e_rn = 1'b0;
            end else begin
                g = -1;
                e_ready = '0;
                e_busy  = 1'b1;
                e_rn    = (d >= 2);
                e_start = (d == 2);
                if (cyc == m_resp) begin
                    e_rv   = N'(1 << m_owner);
                    e_err  = m_perr;
                    m_last = m_pend;
                end
            end
            chk("req_ready", req_ready, e_ready);
            chk("busy", busy, e_busy);
            chk("core_resetn", core_resetn, e_rn);
            chk("core_start", core_start, e_start);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("rsp_error", rsp_error, e_err);
            chk("rsp_result", rsp_result, m_last);
            chk("core_a", core_a, m_a);
            chk("core_b", core_b, m_b);
            chk("core_m", core_m, m_m);
            if (reset) begin
                // nothing advances while reset is held
            end else if (m_busy == 0) begin
                if (g >= 0) begin
                    m_busy = 1; m_acc = cyc; m_owner = g; m_resp = -1;
                    m_a = req_a[g*W +: W]; m_b = req_b[g*W +: W]; m_m = req_m[g*W +: W];
                end
            end else if (cyc == m_resp) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end else if (m_resp < 0 && d >= 3) begin
                if (core_done) begin
                    m_resp = cyc + 1; m_pend = core_result; m_perr = 1'b0;
                end else if (TO_EN && (d - 3) == TO - 1) begin
                    m_resp = cyc + 1; m_pend = '0; m_perr = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b, input int m);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        req_m[i*W +: W] = W'(m);
    endtask

    // which: 0 req_ready, 1 core_start, 2 core_done, 3 rsp_valid
    task automatic wait_for(input int which, output int c, output int idx);
        c = -1;
        idx = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((which == 0 && req_ready != '0) || (which == 1 && core_start) ||
                (which == 2 && core_done) || (which == 3 && rsp_valid != '0)) begin
                c = cyc;
                for (int i = 0; i < N; i++) begin
                    if ((which == 0 && req_ready[i]) || (which == 3 && rsp_valid[i])) idx = i;
                end
                return;
            end
        end
        chk($sformatf("wait_expired_%0d", which), 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int c_acc, c_st, c_dn, c_rsp, idx, cnt;
        int g_arr[4], r_own[4], r_res[4];
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_m = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_core_resetn", core_resetn, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_core_a", core_a, 0);
        @(posedge clk); #1 reset = 1'b0;

        // single request: 5*7 mod 13 = 9
        set_req(0, 5, 7, 13);
        req_valid = 2'b01;
        wait_for(0, c_acc, idx);
        chk("t1_grant", req_ready, 2'b01);
        tick(); req_valid = '0;
        wait_for(1, c_st, idx);
        chk("t1_start_lat", c_st - c_acc, 2);
        wait_for(2, c_dn, idx);
        wait_for(3, c_rsp, idx);
        chk("t1_rsp_lat", c_rsp - c_dn, 1);
        chk("t1_rsp_owner", rsp_valid, 2'b01);
        chk("t1_result", rsp_result, 9);
        chk("t1_error", rsp_error, 0);
        @(negedge clk);
        chk("t1_rsp_pulse", rsp_valid, 0);
        chk("t1_result_held", rsp_result, 9);

        // contention from reset: grants 0,1,0,1; 3*4%11=1, 6*9%17=3
        do_reset();
        set_req(0, 3, 4, 11);
        set_req(1, 6, 9, 17);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_for(0, c_acc, g_arr[k]);
            wait_for(3, c_rsp, r_own[k]);
            r_res[k] = int'(rsp_result);
        end
        tick(); req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_grant%0d", k), g_arr[k], k % 2);
            chk($sformatf("t2_owner%0d", k), r_own[k], k % 2);
            chk($sformatf("t2_result%0d", k), r_res[k], (k % 2 == 0) ? 1 : 3);
        end

        // withdrawal + done pulse in START: 2*8%5=1
        set_req(0, 2, 8, 5);
        req_valid = 2'b01;
        wait_for(0, c_acc, idx);
        chk("t3_grant", req_ready, 2'b01);
        tick(); req_valid = '0;
        tick(); inject_done = 1'b1;
        tick(); inject_done = 1'b0;
        tick();
        set_req(1, 9, 9, 10);
        req_valid = 2'b10;
        repeat (3) tick();
        req_valid = '0;
        wait_for(3, c_rsp, idx);
        chk("t3_rsp_owner", rsp_valid, 2'b01);
        chk("t3_result", rsp_result, 1);
        chk("t3_rsp_time", c_rsp - c_acc, 13);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_ready[1] || rsp_valid[1]) cnt++;
        end
        chk("t3_withdrawn_served", cnt, 0);

        // reset during WAIT: 4*4%7=2 is lost; next grant goes to 0
        set_req(1, 4, 4, 7);
        tick(); req_valid = 2'b10;
        wait_for(0, c_acc, idx);
        chk("t4_grant", req_ready, 2'b10);
        tick(); req_valid = '0;
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        chk("t4_async_busy", busy, 0);
        chk("t4_async_resetn", core_resetn, 0);
        @(posedge clk); #1 reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid != '0) cnt++;
        end
        chk("t4_no_rsp", cnt, 0);
        set_req(0, 3, 5, 7);
        tick(); req_valid = 2'b11;
        wait_for(0, c_acc, idx);
        chk("t4_grant_after_reset", req_ready, 2'b01);
        tick(); req_valid = '0;
        wait_for(3, c_rsp, idx);
        chk("t4_rsp_owner", rsp_valid, 2'b01);
        chk("t4_result", rsp_result, 1);

`ifdef MONT_ARB_TIMEOUT_EN
        never_done = 1'b1;
        tick(); req_valid = 2'b10;
        wait_for(0, c_acc, idx);
        chk("t5_grant", req_ready, 2'b10);
        tick(); req_valid = '0;
        wait_for(3, c_rsp, idx);
        chk("t5_rsp_owner", rsp_valid, 2'b10);
        chk("t5_error", rsp_error, 1);
        chk("t5_result", rsp_result, 0);
        chk("t5_rsp_time", c_rsp - c_acc, 19);
        never_done = 1'b0;
        tick(); req_valid = 2'b01;
        wait_for(0, c_acc, idx);
        tick(); req_valid = '0;
        wait_for(3, c_rsp, idx);
        chk("t5_next_owner", rsp_valid, 2'b01);
        chk("t5_next_error", rsp_error, 0);
        chk("t5_next_result", rsp_result, 1);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mont_arbiter.md
# mont_arbiter

Shares a single `montgomery` multiplier core between `NUM_REQ` independent requesters, such as the exponentiation engine and a standalone modular-multiply port. The block accepts one operand set at a time using round-robin arbitration, sequences the core's reset/start/done protocol, and returns the result with a one-cycle response pulse to the requester that owns the operation. It sits between the requester blocks and the one `montgomery` instance in the datapath.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `WIDTH`, 1024: operand and result width in bits.
- `TIMEOUT_CYCLES`, 4096: watchdog limit; only used with `MONT_ARB_TIMEOUT_EN`.

- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req_valid`  in  NUM_REQ  per-requester operation request; held until `req_ready`.
- `req_a`, `req_b`, `req_m`  in  NUM_REQ*WIDTH each  flattened operands; requester i uses slice [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  one-hot grant/accept pulse; operands are sampled on this edge.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `rsp_result`  out  WIDTH  result of the last completed operation; held until the next completion.
- `rsp_error`  out  1  qualifies `rsp_valid`; 1 means timeout abort.
- `busy`  out  1  high in every state except IDLE.
- `core_resetn`  out  1  drives the core's active-low reset.
- `core_start`  out  1  core start pulse.
- `core_a`, `core_b`, `core_m`  out  WIDTH each  registered operands.
- `core_result`  in  WIDTH  core result.
- `core_done`  in  1  core completion.

## Operation
- **State machine:** IDLE → LOAD → START → WAIT → RESP → IDLE.
- **IDLE:**
  - `core_resetn`=0.
  - If any `req_valid` is set, assert `req_ready[g]` combinationally for the round-robin winner g.
  - On the same edge, capture that requester's operands into `core_a`/`core_b`/`core_m`, latch g as owner, and go to LOAD.
- **LOAD:** `core_resetn`=0 for one cycle, which flushes the core.
- **START:** `core_resetn`=1 and `core_start`=1 for exactly one cycle.
- **WAIT:**
  - `core_resetn`=1, `core_start`=0.
  - When `core_done`=1, capture `core_result` into `rsp_result` and go to RESP.
- **RESP:**
  - `rsp_valid[owner]`=1 for one cycle.
  - Round-robin pointer becomes (owner+1) mod NUM_REQ.
  - Return to IDLE.
- **Arbitration:** round-robin. After reset the pointer is 0. The search starts at the pointer index and wraps.
- A requester that drops `req_valid` before it is granted is never served. No request is queued.
- `req_valid` sampled outside IDLE is ignored; the requester keeps it asserted.
- `core_done` seen in LOAD or START is ignored.
- `core_result` is ignored outside WAIT.
- Operands stay stable in `core_a`/`b`/`m` from LOAD through RESP.

## Timing
- **Reset values:**
  - State IDLE, pointer 0.
  - `req_ready`=0 (no valid input), `rsp_valid`=0, `rsp_error`=0, `busy`=0.
  - `core_start`=0, `core_resetn`=0.
  - `rsp_result`=0, `core_a`/`b`/`m`=0.
- **Latency:**
  - Accept edge (cycle 0) → `core_start` high in cycle 2.
  - `core_done` first sampled high at edge k → `rsp_valid` high in cycle k+1.
  - Next accept is possible in the cycle after RESP.
  - Minimum overhead is 4 cycles plus the core latency.
- **Reset mid-operation:**
  - Immediate return to IDLE; `core_resetn` drops asynchronously.
  - No `rsp_valid` is issued and the operation is lost. Requesters re-issue.
- **Simultaneous requests:** exactly one `req_ready` bit is high. It is never asserted while `busy`.

## Configuration
- **`MONT_ARB_TIMEOUT_EN` defined:**
  - A counter runs in WAIT and clears on entry.
  - If it reaches `TIMEOUT_CYCLES` without `core_done`, go to RESP with `rsp_error`=1 and `rsp_result`=0.
  - The pointer advances normally.
- **`MONT_ARB_TIMEOUT_EN` undefined:**
  - No counter is built and `rsp_error` is tied to 0.
  - WAIT waits indefinitely.

## Test plan
- **Single request:** requester 0 sends a=5, b=7, m=13 (core model with 10-cycle latency) → `req_ready[0]` on the accept edge; `core_start` 2 cycles later; `rsp_valid[0]` 1 cycle after `core_done`; `rsp_result` equals the model output; `rsp_error`=0.
- **Contention:** `req_valid`=2'b11 held continuously → grants alternate 0,1,0,1. Each `rsp_valid` goes to the matching owner with the correct operands.
- **Withdrawal and ignored done:** requester 1 asserts `req_valid` while requester 0 is in WAIT, then drops it before RESP → requester 1 gets no grant and no response. Pulsing `core_done` during START has no effect.
- **Reset mid-operation:** `reset` asserted in WAIT → `busy`=0 and `core_resetn`=0 immediately. No `rsp_valid`. The next grant goes to requester 0.
- **Timeout** (`MONT_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, core never done) → `rsp_valid[g]` with `rsp_error`=1 and `rsp_result`=0, 16 cycles after entering WAIT. The following request completes normally.
